// File: rtl/lap_stopwatch_core_pkg.sv
// Shared types, FSM state codes and time-layout helpers for the lap stopwatch core.
// Packed time layout (LSB first): tenths, seconds units, seconds tens, then minute digits.
package lap_stopwatch_core_pkg;

    localparam int MAX_MIN_DIGITS = 3;
    localparam int MAX_TIME_W     = 12 + 4 * MAX_MIN_DIGITS;

    typedef logic [3:0]            bcd_t;
    typedef logic [MAX_TIME_W-1:0] time_max_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    function automatic int time_w(input int min_digits);
        return 12 + 4 * min_digits;
    endfunction

    // Digit 2 is the seconds-tens digit, the only one that rolls over at 5.
    function automatic bcd_t digit_limit(input int k);
        return (k == 2) ? 4'd5 : 4'd9;
    endfunction

    // Binary minutes/seconds to the packed BCD layout, zero tenths; caller slices to TIME_W.
    function automatic time_max_t preset_time(input int unsigned pmin, input int unsigned psec);
        time_max_t t;
        t        = '0;
        t[23:20] = bcd_t'((pmin / 100) % 10);
        t[19:16] = bcd_t'((pmin / 10) % 10);
        t[15:12] = bcd_t'(pmin % 10);
        t[11:8]  = bcd_t'(psec / 10);
        t[7:4]   = bcd_t'(psec % 10);
        return t;
    endfunction

endpackage

// File: rtl/lap_stopwatch_core_if.sv
// Button pulses in, BCD digits and status out; master drives buttons, slave is the core.
interface lap_stopwatch_core_if #(
    parameter int MIN_DIGITS = 1,
    parameter int LAP_DEPTH  = 4
);
    localparam int LI_W = $clog2(LAP_DEPTH);

    logic                    start_button;
    logic                    stop_button;
    logic                    clear_button;
    logic                    count_down;
    logic                    lap_button;
    logic                    recall_button;
    logic [4*MIN_DIGITS-1:0] digit_minute;
    logic [3:0]              digit_sec_tens;
    logic [3:0]              digit_sec_units;
    logic [3:0]              digit_tenths;
    logic                    running;
    logic                    direction;
    logic                    expired;
    logic                    lap_view;
    logic [LI_W-1:0]         lap_index;
    logic [LI_W:0]           lap_count;
    logic                    lap_full;

    modport master (
        output start_button, stop_button, clear_button, count_down, lap_button, recall_button,
        input  digit_minute, digit_sec_tens, digit_sec_units, digit_tenths,
        input  running, direction, expired, lap_view, lap_index, lap_count, lap_full
    );

    modport slave (
        input  start_button, stop_button, clear_button, count_down, lap_button, recall_button,
        output digit_minute, digit_sec_tens, digit_sec_units, digit_tenths,
        output running, direction, expired, lap_view, lap_index, lap_count, lap_full
    );

endinterface

// File: rtl/lap_stopwatch_core_bcd_time_counter.sv
// Cascaded BCD M:SS.t counter: load has priority over a single up/down step per cycle.
// A digit steps when every lower digit sits at its terminal value for the current direction.
module bcd_time_counter
    import lap_stopwatch_core_pkg::*;
#(
    parameter int MIN_DIGITS = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_i,
    input  logic [12+4*MIN_DIGITS-1:0]  load_val_i,
    input  logic                        step_i,
    input  logic                        dir_i,
    output logic [12+4*MIN_DIGITS-1:0]  time_o,
    output logic                        is_zero_o,
    output logic                        last_dn_o
);
    localparam int TIME_W = time_w(MIN_DIGITS);
    localparam int NDIG   = 3 + MIN_DIGITS;

    logic [TIME_W-1:0] time_q, time_d, stepped;
    logic [NDIG-1:0]   term_up, term_dn;
    logic              is_max;

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        localparam bcd_t LIM = digit_limit(k);
        bcd_t cur;
        logic cin;

        assign cur        = time_q[4*k +: 4];
        assign term_up[k] = (cur == LIM);
        assign term_dn[k] = (cur == 4'd0);

        if (k == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_upper
            assign cin = dir_i ? &term_up[k-1:0] : &term_dn[k-1:0];
        end

        assign stepped[4*k +: 4] = !cin  ? cur :
                                   dir_i ? (term_up[k] ? 4'd0 : cur + 4'd1) :
                                           (term_dn[k] ? LIM  : cur - 4'd1);
    end

    assign is_max    = &term_up;
    assign is_zero_o = &term_dn;
    // Exactly 0:00.1, so the next down step lands on zero.
    assign last_dn_o = (time_q[3:0] == 4'd1) && (&term_dn[NDIG-1:1]);

    assign time_d = load_i ? load_val_i :
                    step_i ? ((dir_i && is_max) ? '0 : stepped) :
                             time_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch/countdown core: run FSM, tick prescaler, lap store and registered digit view mux.
// Digits trail the time counter by one edge so live and recalled values share one output register.
module lap_stopwatch_core
    import lap_stopwatch_core_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 10,
    parameter int MIN_DIGITS = 1,
    parameter int LAP_DEPTH  = 4,
    parameter int PRESET_MIN = 1,
    parameter int PRESET_SEC = 0
) (
    input  logic              clock,
    input  logic              reset,
    lap_stopwatch_core_if.slave sw
);
    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W      = $clog2(TICK_DIV);
    localparam int PS_LAST_I = TICK_DIV - 1;
    localparam int TIME_W    = time_w(MIN_DIGITS);
    localparam int LI_W      = $clog2(LAP_DEPTH);

    localparam logic [PS_W-1:0]   PS_LAST     = PS_LAST_I[PS_W-1:0];
    localparam logic [LI_W:0]     LAP_MAX     = LAP_DEPTH[LI_W:0];
    localparam time_max_t         PRESET_FULL = preset_time(PRESET_MIN, PRESET_SEC);
    localparam logic [TIME_W-1:0] PRESET_T    = PRESET_FULL[TIME_W-1:0];

    logic [1:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [LI_W:0]     lap_cnt_q, lap_cnt_d;
    logic              lap_full_q, lap_full_d;
    logic              view_q, view_d;
    logic [LI_W-1:0]   idx_q, idx_d;
    logic              running_q, running_d;
    logic              expired_q, expired_d;
    logic [TIME_W-1:0] disp_q, disp_d;
    logic [TIME_W-1:0] lap_mem_q [LAP_DEPTH];

    logic              lap_we;
    logic              tick;
    logic              cnt_load, cnt_step, cnt_zero, cnt_last_dn;
    logic [TIME_W-1:0] cnt_val, cnt_time;
    logic              idle_or_pause;

    bcd_time_counter #(
        .MIN_DIGITS (MIN_DIGITS)
    ) u_time (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .step_i     (cnt_step),
        .dir_i      (dir_q),
        .time_o     (cnt_time),
        .is_zero_o  (cnt_zero),
        .last_dn_o  (cnt_last_dn)
    );

    assign tick          = (state_q == ST_RUN) && (ps_q == PS_LAST);
    assign idle_or_pause = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

    // Highest-priority pulse present is the only one acted on, even when it turns out a no-op.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        ps_d      = ps_q;
        lap_cnt_d = lap_cnt_q;
        view_d    = view_q;
        idx_d     = idx_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_step  = 1'b0;
        lap_we    = 1'b0;

        if (sw.clear_button) begin
            state_d   = ST_IDLE;
            ps_d      = '0;
            lap_cnt_d = '0;
            view_d    = 1'b0;
            idx_d     = '0;
            cnt_load  = 1'b1;
            cnt_val   = dir_q ? '0 : PRESET_T;
        end else if (sw.stop_button) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else begin
            if (state_q == ST_RUN) begin
                ps_d = tick ? '0 : ps_q + 1'b1;
                if (tick) begin
                    cnt_step = 1'b1;
                    if (!dir_q && cnt_last_dn) begin
                        state_d = ST_EXPIRED;
                    end
                end
            end

            if (sw.start_button) begin
                if (idle_or_pause && !(!dir_q && cnt_zero)) begin
                    state_d = ST_RUN;
                    ps_d    = '0;
                    view_d  = 1'b0;
                    idx_d   = '0;
                end
            end else if (sw.count_down) begin
                if (idle_or_pause) begin
                    dir_d = ~dir_q;
                end
            end else if (sw.lap_button) begin
                if ((state_q == ST_RUN) && !lap_full_q) begin
                    lap_we    = 1'b1;
                    lap_cnt_d = lap_cnt_q + 1'b1;
                end
            end else if (sw.recall_button) begin
                if ((state_q != ST_RUN) && (lap_cnt_q != '0)) begin
                    if (!view_q) begin
                        view_d = 1'b1;
                        idx_d  = '0;
                    end else if ({1'b0, idx_q} == lap_cnt_q - 1'b1) begin
                        view_d = 1'b0;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        end

        running_d  = (state_d == ST_RUN);
        expired_d  = (state_d == ST_EXPIRED);
        lap_full_d = (lap_cnt_d == LAP_MAX);
    end

    assign disp_d = view_q ? lap_mem_q[idx_q] : cnt_time;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b1;
            ps_q       <= '0;
            lap_cnt_q  <= '0;
            lap_full_q <= 1'b0;
            view_q     <= 1'b0;
            idx_q      <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            ps_q       <= ps_d;
            lap_cnt_q  <= lap_cnt_d;
            lap_full_q <= lap_full_d;
            view_q     <= view_d;
            idx_q      <= idx_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            disp_q     <= disp_d;
        end
    end

    // Lap entries are only meaningful below lap_count, so they carry no reset.
    always_ff @(posedge clock) begin
        if (!reset && lap_we) begin
            lap_mem_q[lap_cnt_q[LI_W-1:0]] <= cnt_time;
        end
    end

    assign sw.digit_minute    = disp_q[TIME_W-1:12];
    assign sw.digit_sec_tens  = disp_q[11:8];
    assign sw.digit_sec_units = disp_q[7:4];
    assign sw.digit_tenths    = disp_q[3:0];
    assign sw.running         = running_q;
    assign sw.direction       = dir_q;
    assign sw.expired         = expired_q;
    assign sw.lap_view        = view_q;
    assign sw.lap_index       = idx_q;
    assign sw.lap_count       = lap_cnt_q;
    assign sw.lap_full        = lap_full_q;

endmodule
